sprite_rom_arbiter: RTL

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one sprite ROM between NUM_REQ pixel-pipeline requesters.
// Grants are issued in the request cycle; read data comes back tagged one-hot on rvalid.
module sprite_rom_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                          vga_pix_clk,
  input  logic                          rst,
  input  logic                          frame_stb,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          rom_en,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [NUM_REQ-1:0]            rvalid
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned Depth = ROM_LATENCY + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sprite_rom_arbiter: NUM_REQ must be in 2..8");
  end
  if (ROM_LATENCY < 1 || ROM_LATENCY > 3) begin : g_bad_latency
    $error("sprite_rom_arbiter: ROM_LATENCY must be in 1..3");
  end

  logic [IdxW-1:0]             ptr_q;
  logic                        gnt_any;
  logic [IdxW-1:0]             gnt_idx;
  logic [IdxW-1:0]             cand;
  logic [Depth-1:0]            vld_q;
  logic [Depth-1:0][IdxW-1:0]  own_q;

  // Search starts one past the last winner so every held requester is served within NUM_REQ cycles.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any && !rst && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge vga_pix_clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= IdxW'(NUM_REQ - 1);
      vld_q    <= '0;
      own_q    <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= gnt_any;
      if (gnt_any) begin
        rom_addr <= addr[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
      end
      // Owner pipeline lines up each issue with the cycle its ROM word appears.
      vld_q <= {vld_q[Depth-2:0], gnt_any};
      own_q <= {own_q[Depth-2:0], gnt_idx};
      if (frame_stb) begin
        ptr_q <= IdxW'(NUM_REQ - 1);
      end else if (gnt_any) begin
        ptr_q <= gnt_idx;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (vld_q[Depth-1]) begin
      rvalid[own_q[Depth-1]] = 1'b1;
      rdata                  = rom_data;
    end
  end

endmodule
